// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Instruction-fetch stage feeding the control unit. Holds the architectural
//   PC, fetches one instruction at a time over a req/ready handshake, presents
//   it to decode, and on retire selects the next PC from pc_src / imm_ext.
//
// Ports
//   clk         in   1   rising-edge system clock
//   reset_n     in   1   asynchronous active-low reset
//   pc_src      in   2   00 PC+4, 01 branch PC+imm, 10 JAL PC+imm, 11 PC+4
//   imm_ext     in   32  sign-extended immediate
//   instr_done  in   1   retire pulse for the current instruction
//   imem_req    out  1   fetch request (high while fetching)
//   imem_addr   out  32  fetch address, always equal to pc
//   imem_ready  in   1   instruction memory data valid
//   imem_rdata  in   32  instruction word
//   instr       out  32  instruction register
//   instr_valid out  1   instr holds a fetched, unretired instruction
//   pc          out  32  PC of the current instruction
//   pc_plus4    out  32  pc + 4 (registered link value)
//   fetch_err   out  1   sticky error flag, cleared only by reset
//
// Build option
//   IMEM_TIMEOUT_EN : when defined, a FETCH that sees no imem_ready for
//   TIMEOUT_CYCLES consecutive cycles raises fetch_err and parks in ERROR.
//   When undefined, FETCH waits indefinitely and no counter is built.

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic        instr_done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    ERROR = 2'b11
  } state_t;

  // Reject parameter values the datapath cannot honour.
  if ((RESET_PC[1:0] != 2'b00) || (TIMEOUT_CYCLES == 32'd0)) begin : g_param_check
    $error("pc_fetch_unit: RESET_PC must be word-aligned and TIMEOUT_CYCLES nonzero");
  end

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] pc4_r, pc4_nxt_s;
  logic [31:0] instr_r, instr_nxt_s;
  logic        valid_r, valid_nxt_s;
  logic        err_r, err_nxt_s;
  logic        req_r, req_nxt_s;
  logic [31:0] target_s;

`ifdef IMEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] cnt_r, cnt_nxt_s;
`endif

  // Candidate next PC; reserved pc_src 11 falls back to sequential.
  always_comb begin
    case (pc_src)
      2'b01, 2'b10: target_s = pc_r + imm_ext;
      default:      target_s = pc_r + 32'd4;
    endcase
  end

  // Next-state and next-register-value logic for the fetch FSM.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    pc4_nxt_s   = pc4_r;
    instr_nxt_s = instr_r;
    valid_nxt_s = valid_r;
    err_nxt_s   = err_r;
`ifdef IMEM_TIMEOUT_EN
    cnt_nxt_s   = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        state_nxt_s = FETCH;
`ifdef IMEM_TIMEOUT_EN
        cnt_nxt_s   = '0;
`endif
      end
      FETCH: begin
        // A ready in the limit cycle still wins over the timeout.
        if (imem_ready) begin
          instr_nxt_s = imem_rdata;
          valid_nxt_s = 1'b1;
          state_nxt_s = EXEC;
        end else begin
`ifdef IMEM_TIMEOUT_EN
          if (cnt_r == CNT_LAST) begin
            err_nxt_s   = 1'b1;
            state_nxt_s = ERROR;
          end else begin
            cnt_nxt_s   = cnt_r + TW'(1'b1);
          end
`else
          state_nxt_s = FETCH;
`endif
        end
      end
      EXEC: begin
        if (instr_done) begin
          valid_nxt_s = 1'b0;
          if (target_s[1:0] == 2'b00) begin
            pc_nxt_s    = target_s;
            pc4_nxt_s   = target_s + 32'd4;
            state_nxt_s = FETCH;
`ifdef IMEM_TIMEOUT_EN
            cnt_nxt_s   = '0;
`endif
          end else begin
            // Misaligned target: keep the faulting instruction's PC visible.
            err_nxt_s   = 1'b1;
            state_nxt_s = ERROR;
          end
        end else begin
          state_nxt_s = EXEC;
        end
      end
      ERROR: begin
        valid_nxt_s = 1'b0;
        err_nxt_s   = 1'b1;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    // Request is registered from the next state so it is glitch-free.
    req_nxt_s = (state_nxt_s == FETCH);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r    <= RESET_PC;
      pc4_r   <= RESET_PC + 32'd4;
      instr_r <= 32'd0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      req_r   <= 1'b0;
`ifdef IMEM_TIMEOUT_EN
      cnt_r   <= '0;
`endif
    end else begin
      pc_r    <= pc_nxt_s;
      pc4_r   <= pc4_nxt_s;
      instr_r <= instr_nxt_s;
      valid_r <= valid_nxt_s;
      err_r   <= err_nxt_s;
      req_r   <= req_nxt_s;
`ifdef IMEM_TIMEOUT_EN
      cnt_r   <= cnt_nxt_s;
`endif
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign instr       = instr_r;
  assign instr_valid = valid_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc4_r;
  assign fetch_err   = err_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  pc_src;
  logic [31:0] imm_ext;
  logic        instr_done;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc_src     (pc_src),
    .imm_ext    (imm_ext),
    .instr_done (instr_done),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fetch_err  (fetch_err)
  );

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] exp_pc;
    logic        exp_err;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reset, check reset values, release, and check the first request.
  task automatic do_reset();
    reset_n = 1'b0; imem_ready = 1'b0; instr_done = 1'b0;
    pc_src = 2'b00; imm_ext = 32'd0; imem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    reset_n = 1'b1;
    model_pc = 32'h0;
    @(negedge clk);
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
  endtask

  // Fetch with `stall` not-ready cycles (random ignored retire pulses), then capture.
  task automatic do_fetch(input int stall, input logic [31:0] data);
    int w = 0;
    while (!imem_req && w < 4) begin
      @(negedge clk);
      w++;
    end
    chk("req_wait", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < stall; i++) begin
      imem_ready = 1'b0; imem_rdata = $urandom;
      instr_done = 1'($urandom_range(0, 1));
      pc_src = 2'($urandom_range(0, 3)); imm_ext = $urandom;
      @(negedge clk);
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, model_pc);
      chk("stall_valid", {31'd0, instr_valid}, 32'd0);
    end
    instr_done = 1'b0; imem_ready = 1'b1; imem_rdata = data;
    @(negedge clk);
    imem_ready = 1'b0; imem_rdata = $urandom;
    chk("cap_instr", instr, data);
    chk("cap_valid", {31'd0, instr_valid}, 32'd1);
    chk("cap_pc", pc, model_pc);
    chk("cap_pc4", pc_plus4, model_pc + 32'd4);
    chk("cap_req", {31'd0, imem_req}, 32'd0);
    chk("cap_err", {31'd0, fetch_err}, 32'd0);
  endtask

  // Hold in EXEC with noise on memory inputs, then retire and check next PC.
  task automatic do_retire(input int hold, input logic [1:0] src, input logic [31:0] imm,
                           input logic [31:0] data, output logic is_err);
    logic [31:0] nxt;
    for (int i = 0; i < hold; i++) begin
      imem_ready = 1'($urandom_range(0, 1)); imem_rdata = $urandom; instr_done = 1'b0;
      @(negedge clk);
      chk("exec_instr", instr, data);
      chk("exec_valid", {31'd0, instr_valid}, 32'd1);
      chk("exec_req", {31'd0, imem_req}, 32'd0);
    end
    nxt = (src == 2'd1 || src == 2'd2) ? model_pc + imm : model_pc + 32'd4;
    is_err = (nxt[1:0] != 2'b00);
    imem_ready = 1'b0; instr_done = 1'b1; pc_src = src; imm_ext = imm;
    @(negedge clk);
    instr_done = 1'b0; pc_src = 2'($urandom_range(0, 3)); imm_ext = $urandom;
    chk("ret_valid", {31'd0, instr_valid}, 32'd0);
    if (!is_err) begin
      model_pc = nxt;
      chk("ret_pc", pc, model_pc);
      chk("ret_pc4", pc_plus4, model_pc + 32'd4);
      chk("ret_req", {31'd0, imem_req}, 32'd1);
      chk("ret_addr", imem_addr, model_pc);
      chk("ret_err", {31'd0, fetch_err}, 32'd0);
    end else begin
      chk("mis_pc", pc, model_pc);
      chk("mis_err", {31'd0, fetch_err}, 32'd1);
      chk("mis_req", {31'd0, imem_req}, 32'd0);
      for (int i = 0; i < 3; i++) begin
        imem_ready = 1'b1; instr_done = 1'b1; imem_rdata = $urandom;
        @(negedge clk);
        chk("errhold_err", {31'd0, fetch_err}, 32'd1);
        chk("errhold_req", {31'd0, imem_req}, 32'd0);
        chk("errhold_valid", {31'd0, instr_valid}, 32'd0);
        chk("errhold_pc", pc, model_pc);
      end
      imem_ready = 1'b0; instr_done = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e;
    logic [31:0] d;
    logic [1:0]  s;
    logic [31:0] im;

    tbl[0]  = '{2'b00, 32'hDEAD_BEEF, 32'h0000_0004, 1'b0};
    tbl[1]  = '{2'b01, 32'h0000_003C, 32'h0000_0040, 1'b0};
    tbl[2]  = '{2'b01, 32'hFFFF_FFF0, 32'h0000_0030, 1'b0};
    tbl[3]  = '{2'b10, 32'h0000_0010, 32'h0000_0040, 1'b0};
    tbl[4]  = '{2'b10, 32'h0000_0100, 32'h0000_0140, 1'b0};
    tbl[5]  = '{2'b11, 32'h0000_0055, 32'h0000_0144, 1'b0};
    tbl[6]  = '{2'b00, 32'h0000_0000, 32'h0000_0148, 1'b0};
    tbl[7]  = '{2'b01, 32'hFFFF_FEB8, 32'h0000_0000, 1'b0};
    tbl[8]  = '{2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    tbl[9]  = '{2'b00, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[10] = '{2'b01, 32'h0000_0010, 32'h0000_0010, 1'b0};
    tbl[11] = '{2'b00, 32'h0000_0000, 32'h0000_0014, 1'b0};
    tbl[12] = '{2'b01, 32'h0000_000C, 32'h0000_0020, 1'b0};
    tbl[13] = '{2'b01, 32'h0000_0002, 32'h0000_0020, 1'b1};

    // Directed vector table.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      d = 32'h1000_0000 + 32'(i);
      do_fetch((i == 10) ? 5 : (i % 2), d);
      do_retire(i % 3, tbl[i].src, tbl[i].imm, d, e);
      chk("tbl_pc", pc, tbl[i].exp_pc);
      chk("tbl_err", {31'd0, fetch_err}, {31'd0, tbl[i].exp_err});
    end

    // Reset asserted mid-FETCH drops imem_req immediately.
    do_reset();
    d = 32'hCAFE_0001;
    do_fetch(0, d);
    do_retire(1, 2'b01, 32'h0000_0040, d, e);
    #2 reset_n = 1'b0;
    #1;
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_pc", pc, 32'h0);
    chk("async_pc4", pc_plus4, 32'h4);

`ifdef IMEM_TIMEOUT_EN
    // Memory never ready: error after 16 FETCH cycles.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      imem_ready = 1'b0;
      @(negedge clk);
      chk("to_wait_req", {31'd0, imem_req}, 32'd1);
      chk("to_wait_err", {31'd0, fetch_err}, 32'd0);
    end
    @(negedge clk);
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_req", {31'd0, imem_req}, 32'd0);
    chk("to_valid", {31'd0, instr_valid}, 32'd0);
    // Ready on the 16th cycle completes normally.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      imem_ready = 1'b0;
      @(negedge clk);
    end
    imem_ready = 1'b1; imem_rdata = 32'h5A5A_0016;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("to_last_instr", instr, 32'h5A5A_0016);
    chk("to_last_valid", {31'd0, instr_valid}, 32'd1);
    chk("to_last_err", {31'd0, fetch_err}, 32'd0);
`endif

    // Randomized instruction stream against the arithmetic model.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      d = $urandom;
      do_fetch($urandom_range(0, 5), d);
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) im = $urandom;
      else if ($urandom_range(0, 1) == 0) im = $urandom & 32'hFFFF_FFFC;
      else im = 32'($urandom_range(0, 64)) << 2;
      do_retire($urandom_range(0, 3), s, im, d, e);
      if (e) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
